timer_ctrl: RTL

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/timer_ctrl.sv
// Timer sequencer: presets and starts an external timer, supervises busy/alarm,
// cuts the timer after each run and repeats the run cmd_repeat extra times.
module timer_ctrl #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned CUT_CYCLES = 2,
    parameter int unsigned START_TMO  = 8
) (
    input  logic             clk,
    input  logic             cut_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_up,
    input  logic [WIDTH-1:0] cmd_sec,
    input  logic [WIDTH-1:0] cmd_min,
    input  logic [WIDTH-1:0] cmd_hour,
    input  logic [7:0]       cmd_repeat,
    input  logic             abort,
    output logic             tmr_write,
    output logic             tmr_start,
    output logic             tmr_up,
    output logic [WIDTH-1:0] tmr_insec,
    output logic [WIDTH-1:0] tmr_inmin,
    output logic [WIDTH-1:0] tmr_inhour,
    output logic             tmr_cut_n,
    input  logic             tmr_buzy_n,
    input  logic             tmr_alarm,
    output logic             done,
    output logic             aborted,
    output logic             err,
    output logic [7:0]       runs_left
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_WAIT_BUSY = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;
    localparam logic [2:0] S_CUT       = 3'd5;

    localparam logic [1:0] END_DONE  = 2'd0;
    localparam logic [1:0] END_ABORT = 2'd1;
    localparam logic [1:0] END_ERR   = 2'd2;

    localparam int unsigned     TMO_W    = (START_TMO > 1) ? $clog2(START_TMO) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(START_TMO - 1);
    localparam logic [3:0]       CUT_LAST = 4'(CUT_CYCLES - 1);

    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic [TMO_W-1:0] wait_cnt;
    logic [3:0]       cut_cnt;
    logic             final_run;
    logic [1:0]       end_kind;

    logic cmd_bad;
    logic accept;
    logic reject;
    logic abort_hit;
    logic tmo_hit;
    logic alarm_hit;
    logic cut_exit;

    assign cmd_bad = (cmd_sec > WIDTH'(59)) || (cmd_min > WIDTH'(59));

    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        reject    = 1'b0;
        abort_hit = 1'b0;
        tmo_hit   = 1'b0;
        alarm_hit = 1'b0;
        cut_exit  = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_bad) begin
                        reject = 1'b1;
                    end else begin
                        accept   = 1'b1;
                        state_nx = S_LOAD;
                    end
                end
            end
            S_LOAD:  state_nx = S_START;
            S_START: state_nx = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (!tmr_buzy_n) begin
                    state_nx = S_RUN;
                end else if (wait_cnt == TMO_LAST) begin
                    tmo_hit  = 1'b1;
                    state_nx = S_CUT;
                end
            end
            S_RUN: begin
                if (tmr_alarm) begin
                    alarm_hit = 1'b1;
                    state_nx  = S_CUT;
                end
            end
            S_CUT: begin
                if (cut_cnt == CUT_LAST) begin
                    cut_exit = 1'b1;
                    state_nx = final_run ? S_IDLE : S_LOAD;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        // Abort overrides any alarm or timeout seen in the same cycle.
        if (abort && (state == S_LOAD || state == S_START ||
                      state == S_WAIT_BUSY || state == S_RUN)) begin
            abort_hit = 1'b1;
            tmo_hit   = 1'b0;
            alarm_hit = 1'b0;
            state_nx  = S_CUT;
        end
    end

    // Strobes are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge cut_n) begin
        if (!cut_n) begin
            state      <= S_IDLE;
            cmd_ready  <= 1'b0;
            tmr_write  <= 1'b0;
            tmr_start  <= 1'b0;
            tmr_up     <= 1'b0;
            tmr_insec  <= '0;
            tmr_inmin  <= '0;
            tmr_inhour <= '0;
            tmr_cut_n  <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            err        <= 1'b0;
            runs_left  <= '0;
            wait_cnt   <= '0;
            cut_cnt    <= '0;
            final_run  <= 1'b0;
            end_kind   <= END_DONE;
        end else begin
            state     <= state_nx;
            cmd_ready <= (state_nx == S_IDLE);
            tmr_write <= (state_nx == S_LOAD);
            tmr_start <= (state_nx == S_START);
            tmr_cut_n <= (state_nx != S_CUT);
            err       <= reject || tmo_hit;
            done      <= cut_exit && final_run && (end_kind == END_DONE);
            aborted   <= cut_exit && final_run && (end_kind == END_ABORT);
            wait_cnt  <= (state == S_WAIT_BUSY) ? wait_cnt + 1'b1 : '0;
            cut_cnt   <= (state == S_CUT) ? cut_cnt + 1'b1 : '0;

            if (accept) begin
                tmr_up     <= cmd_up;
                tmr_insec  <= cmd_sec;
                tmr_inmin  <= cmd_min;
                tmr_inhour <= cmd_hour;
                runs_left  <= cmd_repeat;
                final_run  <= 1'b0;
                end_kind   <= END_DONE;
            end
            if (abort_hit) begin
                final_run <= 1'b1;
                end_kind  <= END_ABORT;
            end
            if (tmo_hit) begin
                final_run <= 1'b1;
                end_kind  <= END_ERR;
            end
            if (alarm_hit) begin
                if (runs_left != 8'd0) begin
                    runs_left <= runs_left - 8'd1;
                end else begin
                    final_run <= 1'b1;
                end
            end
        end
    end

endmodule
